platform_collision_scanner: RTL and testbench

- Consumer end of the platform position/activation bus; produces the `move_collision` strobe that the platform bank consumes.
- Once per frame it scans all platform slots, one per clock, against the doodle's feet.
- Reports the landing platform (index, top edge) and whether the landing must trigger a world scroll.
- Sits between the platform bank, the doodle physics block and the scroll logic.

---
 rtl/doodle_pkg.sv | 25 ++
 rtl/platform_hit_test.sv | 35 +++
 rtl/platform_collision_scanner.sv | 126 ++++++++++++
 tb/tb_platform_collision_scanner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle platform/physics/scroll blocks.
package doodle_pkg;

   localparam int N_PLATFORMS = 90;
   localparam int PLAT_W      = 100;
   localparam int PLAT_H      = 20;
   localparam int DOODLE_W    = 80;
   localparam int DOODLE_H    = 80;
   localparam int LAND_TOL    = 12;
   localparam int SCROLL_LINE = 300;
   localparam int IDX_W       = 7;

   typedef struct packed {
      logic signed [10:0] y;
      logic signed [10:0] x;
   } platform_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SNAP,
      S_SCAN,
      S_DONE
   } scan_state_t;

endpackage

// File: rtl/platform_hit_test.sv
// Combinational landing test of the doodle's feet against a single platform slot.
module platform_hit_test
   import doodle_pkg::*;
(
   input  platform_t          plat,
   input  logic               active,
   input  logic signed [10:0] doodle_x,
   input  logic        [9:0]  doodle_y,
   input  logic               falling,
   output logic               hit
);

   localparam logic signed [12:0] DOODLE_H13 = 13'(DOODLE_H);
   localparam logic signed [12:0] DOODLE_W13 = 13'(DOODLE_W);
   localparam logic signed [12:0] PLAT_W13   = 13'(PLAT_W);
   localparam logic signed [12:0] TOL_M1     = 13'(LAND_TOL - 1);

   logic signed [12:0] top;
   logic signed [12:0] left;
   logic signed [12:0] dx;
   logic signed [12:0] feet;
   logic               vertical;
   logic               horizontal;

   // Everything widened to 13-bit signed so off-screen (negative) platforms compare correctly.
   assign top  = {{2{plat.y[10]}}, plat.y};
   assign left = {{2{plat.x[10]}}, plat.x};
   assign dx   = {{2{doodle_x[10]}}, doodle_x};
   assign feet = $signed({3'b000, doodle_y}) + DOODLE_H13;

   assign vertical   = (feet >= top) && (feet <= top + TOL_M1);
   assign horizontal = (dx + DOODLE_W13 > left) && (dx < left + PLAT_W13);
   assign hit        = active && falling && vertical && horizontal;

endmodule

// File: rtl/platform_collision_scanner.sv
// Scans every platform slot once per frame, one per clock, and reports the first landing.
module platform_collision_scanner
   import doodle_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_tick,
   input  logic signed [10:0]     platforms [N_PLATFORMS][2],
   input  logic [N_PLATFORMS-1:0] platform_activation,
   input  logic [10:0]            doodle_x,
   input  logic [9:0]             doodle_y,
   input  logic                   doodle_falling,
   output logic                   hit,
   output logic [IDX_W-1:0]       hit_index,
   output logic signed [10:0]     hit_top,
   output logic                   move_collision,
   output logic                   scan_busy,
   output logic                   scan_done,
   output logic                   overrun
);

   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PLATFORMS - 1);
   localparam logic signed [10:0] SCROLL_Y = 11'(SCROLL_LINE);

   scan_state_t        state;
   scan_state_t        state_next;
   logic [IDX_W-1:0]   idx;
   logic signed [10:0] dx_q;
   logic [9:0]         dy_q;
   logic               falling_q;
   logic               found;
   logic [IDX_W-1:0]   found_idx;
   logic signed [10:0] found_top;

   platform_t          cur;
   logic               slot_hit;
   logic               res_hit;
   logic [IDX_W-1:0]   res_idx;
   logic signed [10:0] res_top;

   always_comb begin
      cur.y = platforms[idx][0];
      cur.x = platforms[idx][1];
   end

   platform_hit_test u_hit_test (
      .plat     (cur),
      .active   (platform_activation[idx]),
      .doodle_x (dx_q),
      .doodle_y (dy_q),
      .falling  (falling_q),
      .hit      (slot_hit)
   );

   // Final result folds in the last slot so the outputs are valid on the DONE cycle itself.
   assign res_hit = found || slot_hit;
   assign res_idx = found ? found_idx : idx;
   assign res_top = found ? found_top : cur.y;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (frame_tick) state_next = S_SNAP;
         S_SNAP: state_next = S_SCAN;
         S_SCAN: if (idx == LAST_IDX) state_next = S_DONE;
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign scan_busy = (state != S_IDLE);
   assign scan_done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         idx            <= '0;
         dx_q           <= '0;
         dy_q           <= '0;
         falling_q      <= 1'b0;
         found          <= 1'b0;
         found_idx      <= '0;
         found_top      <= '0;
         hit            <= 1'b0;
         hit_index      <= '0;
         hit_top        <= '0;
         move_collision <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         if (frame_tick && state != S_IDLE) overrun <= 1'b1;
         case (state)
            S_SNAP: begin
               dx_q      <= doodle_x;
               dy_q      <= doodle_y;
               falling_q <= doodle_falling;
               found     <= 1'b0;
               found_idx <= '0;
               found_top <= '0;
               idx       <= '0;
            end
            S_SCAN: begin
               if (!found && slot_hit) begin
                  found     <= 1'b1;
                  found_idx <= idx;
                  found_top <= cur.y;
               end
               if (idx == LAST_IDX) begin
                  idx            <= '0;
                  hit            <= res_hit;
                  hit_index      <= res_hit ? res_idx : '0;
                  hit_top        <= res_hit ? res_top : '0;
                  move_collision <= res_hit && (res_top < SCROLL_Y);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_platform_collision_scanner.sv
// Directed self-checking bench for platform_collision_scanner.
module tb_platform_collision_scanner;
   import doodle_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   frame_tick;
   logic signed [10:0]     platforms [N_PLATFORMS][2];
   logic [N_PLATFORMS-1:0] platform_activation;
   logic [10:0]            doodle_x;
   logic [9:0]             doodle_y;
   logic                   doodle_falling;
   logic                   hit;
   logic [6:0]             hit_index;
   logic signed [10:0]     hit_top;
   logic                   move_collision;
   logic                   scan_busy;
   logic                   scan_done;
   logic                   overrun;

   int n_cmp = 0;
   int n_err = 0;
   int lat;
   int pulses;

   platform_collision_scanner dut (
      .clk                 (clk),
      .rst                 (rst),
      .frame_tick          (frame_tick),
      .platforms           (platforms),
      .platform_activation (platform_activation),
      .doodle_x            (doodle_x),
      .doodle_y            (doodle_y),
      .doodle_falling      (doodle_falling),
      .hit                 (hit),
      .hit_index           (hit_index),
      .hit_top             (hit_top),
      .move_collision      (move_collision),
      .scan_busy           (scan_busy),
      .scan_done           (scan_done),
      .overrun             (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_slots();
      for (int i = 0; i < N_PLATFORMS; i++) begin
         platforms[i][0] = 11'sd0;
         platforms[i][1] = 11'sd0;
      end
      platform_activation = '0;
   endtask

   task automatic set_slot(input int i, input int y, input int x, input logic act);
      platforms[i][0] = 11'(y);
      platforms[i][1] = 11'(x);
      platform_activation[i] = act;
   endtask

   // Ticks, then watches 200 cycles: first scan_done cycle (tick cycle = 0) and pulse count.
   task automatic run_frame(input int extra_tick_at, output int first, output int n_pulse);
      first   = -1;
      n_pulse = 0;
      frame_tick = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         frame_tick = (c == extra_tick_at);
         if (scan_done) begin
            n_pulse++;
            if (first < 0) first = c;
         end
      end
      frame_tick = 1'b0;
   endtask

   task automatic check_result(input string tag, input int e_hit, input int e_idx,
                               input int e_top, input int e_mc);
      check({tag, ".hit"},            int'(hit),            e_hit);
      check({tag, ".hit_index"},      int'(hit_index),      e_idx);
      check({tag, ".hit_top"},        int'(hit_top),        e_top);
      check({tag, ".move_collision"}, int'(move_collision), e_mc);
   endtask

   task automatic set_doodle(input int x, input int y, input logic f);
      doodle_x       = 11'(x);
      doodle_y       = 10'(y);
      doodle_falling = f;
   endtask

   initial begin
      rst        = 1'b1;
      frame_tick = 1'b0;
      clear_slots();
      set_doodle(0, 0, 1'b0);
      repeat (3) @(negedge clk);
      check("reset.hit",       int'(hit),       0);
      check("reset.hit_index", int'(hit_index), 0);
      check("reset.hit_top",   int'(hit_top),   0);
      check("reset.move",      int'(move_collision), 0);
      check("reset.busy",      int'(scan_busy), 0);
      check("reset.done",      int'(scan_done), 0);
      check("reset.overrun",   int'(overrun),   0);
      rst = 1'b0;
      @(negedge clk);

      // Single hit, with latency and one-pulse check.
      set_slot(5, 400, 300, 1'b1);
      set_doodle(320, 325, 1'b1);
      run_frame(0, lat, pulses);
      check("single.latency", lat, 92);
      check("single.pulses",  pulses, 1);
      check("single.busy_after", int'(scan_busy), 0);
      check_result("single", 1, 5, 400, 0);

      // Scroll request.
      set_slot(5, 250, 300, 1'b1);
      set_doodle(320, 175, 1'b1);
      run_frame(0, lat, pulses);
      check_result("scroll", 1, 5, 250, 1);

      // Priority and qualifiers.
      clear_slots();
      set_slot(10, 400, 300, 1'b1);
      set_slot(40, 400, 300, 1'b1);
      set_doodle(320, 325, 1'b1);
      run_frame(0, lat, pulses);
      check_result("prio_first", 1, 10, 400, 0);
      platform_activation[10] = 1'b0;
      run_frame(0, lat, pulses);
      check_result("prio_inactive", 1, 40, 400, 0);
      set_doodle(320, 325, 1'b0);
      run_frame(0, lat, pulses);
      check_result("not_falling", 0, 0, 0, 0);

      // Vertical window edges against slot 40 (top 400).
      set_doodle(320, 332, 1'b1);
      run_frame(0, lat, pulses);
      check("edge_feet_tol.hit", int'(hit), 0);
      set_doodle(320, 331, 1'b1);
      run_frame(0, lat, pulses);
      check_result("edge_feet_tol_m1", 1, 40, 400, 0);
      set_doodle(320, 319, 1'b1);
      run_frame(0, lat, pulses);
      check("edge_feet_above.hit", int'(hit), 0);

      // Horizontal edges (plat x 300..399).
      set_doodle(220, 325, 1'b1);
      run_frame(0, lat, pulses);
      check("edge_left_touch.hit", int'(hit), 0);
      set_doodle(221, 325, 1'b1);
      run_frame(0, lat, pulses);
      check("edge_left_overlap.hit", int'(hit), 1);
      set_doodle(399, 325, 1'b1);
      run_frame(0, lat, pulses);
      check("edge_right_overlap.hit", int'(hit), 1);
      set_doodle(400, 325, 1'b1);
      run_frame(0, lat, pulses);
      check("edge_right_touch.hit", int'(hit), 0);

      // Off-screen platform never hits.
      set_slot(40, -162, 300, 1'b1);
      set_doodle(320, 0, 1'b1);
      run_frame(0, lat, pulses);
      check_result("negative_y", 0, 0, 0, 0);

      // Overrun: second tick mid-scan is ignored.
      set_slot(40, 400, 300, 1'b1);
      set_doodle(320, 325, 1'b1);
      check("pre_overrun.overrun", int'(overrun), 0);
      run_frame(40, lat, pulses);
      check("overrun.latency", lat, 92);
      check("overrun.pulses",  pulses, 1);
      check("overrun.flag",    int'(overrun), 1);
      check_result("overrun", 1, 40, 400, 0);
      run_frame(0, lat, pulses);
      check("overrun.sticky", int'(overrun), 1);

      // Reset mid-scan.
      frame_tick = 1'b1;
      pulses = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         frame_tick = 1'b0;
         rst = (c == 50);
         if (scan_done) pulses++;
         if (c == 51) begin
            check("rst_mid.busy",    int'(scan_busy), 0);
            check("rst_mid.overrun", int'(overrun),   0);
            check_result("rst_mid", 0, 0, 0, 0);
         end
      end
      rst = 1'b0;
      check("rst_mid.pulses", pulses, 0);
      run_frame(0, lat, pulses);
      check("after_rst.latency", lat, 92);
      check_result("after_rst", 1, 40, 400, 0);
      check("after_rst.overrun", int'(overrun), 0);

      // Tick on the DONE cycle counts as busy.
      run_frame(92, lat, pulses);
      check("tick_on_done.pulses",  pulses, 1);
      check("tick_on_done.overrun", int'(overrun), 1);
      check("tick_on_done.busy",    int'(scan_busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
